// File: rtl/raster_scheduler_pkg.sv
// Common types for the raster scheduler: the triangle task record, the
// per-pixel record produced by the rasterizers, and the task FSM encoding.
package raster_scheduler_pkg;

    // One triangle: three screen-space vertices plus a flat colour.
    typedef struct packed {
        logic [15:0] v0_x;
        logic [15:0] v0_y;
        logic [15:0] v1_x;
        logic [15:0] v1_y;
        logic [15:0] v2_x;
        logic [15:0] v2_y;
        logic [23:0] color;
    } object_t;

    // One shaded pixel headed for the framebuffer.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [23:0] color;
    } pixel_info_t;

    // Task-level FSM states.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } scheduler_state_t;

endpackage

// File: rtl/raster_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at 'pointer' and wraps modulo N.
// Produces a one-hot grant and its index; grant is all-zero when req is.
module rr_arbiter #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic found_s;
    int   idx_s;

    // Scan requesters starting at the pointer and pick the first one asserted.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(pointer) + k) % N;
            if (!found_s && req[IW'(idx_s)]) begin
                grant[IW'(idx_s)] = 1'b1;
                grant_idx         = IW'(idx_s);
                found_s           = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// Raster scheduler: issues one triangle at a time to N_RAST rasterizers and
// funnels their pixel pulses into a single framebuffer stream.
// Optional statistics counters are enabled with RASTER_SCHEDULER_STATS_EN.
module raster_scheduler
    import raster_scheduler_pkg::*;
#(
    parameter int N_RAST = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  object_t                  task_in,
    input  logic                     task_valid,
    output logic                     task_ready,
    output object_t                  rast_task,
    output logic                     rast_next_task,
    input  logic [N_RAST-1:0]        rast_task_complete,
    input  pixel_info_t [N_RAST-1:0] rast_data,
    input  logic [N_RAST-1:0]        rast_data_write,
    output logic [N_RAST-1:0]        rast_output_written,
    output pixel_info_t              fb_data,
    output logic                     fb_valid,
    input  logic                     fb_ready,
    output logic                     busy,
    output logic                     overflow_err
`ifdef RASTER_SCHEDULER_STATS_EN
    ,
    output logic [31:0]              pixel_count,
    output logic [15:0]              task_count
`endif
);

    localparam int IDX_W = $clog2(N_RAST);

    scheduler_state_t          state_r, state_next_s;
    logic                      run_first_r;
    logic                      accept_s;
    logic                      task_ready_r, rast_next_task_r, busy_r;
    object_t                   rast_task_r;

    logic [N_RAST-1:0]         pending_r;
    pixel_info_t [N_RAST-1:0]  hold_r;
    logic                      overflow_r;
    logic [IDX_W-1:0]          rr_ptr_r;
    pixel_info_t               fb_data_r;
    logic                      fb_valid_r;
    logic [IDX_W-1:0]          fb_src_r;
    logic [N_RAST-1:0]         ack_r;

    logic                      fire_s, can_load_s, grant_valid_s;
    logic [N_RAST-1:0]         in_flight_s, ack_next_s, arb_req_s, grant_s;
    logic [IDX_W-1:0]          grant_idx_s;

    assign accept_s      = (state_r == ST_IDLE) && task_valid;
    assign fire_s        = fb_valid_r && fb_ready;
    assign can_load_s    = !fb_valid_r || fb_ready;
    assign arb_req_s     = pending_r & ~in_flight_s & {N_RAST{can_load_s}};
    assign grant_valid_s = |grant_s;

    // Next-state logic; the first RUN cycle ignores the stale completion flags.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (&rast_task_complete) state_next_s = ST_IDLE;
                else                     state_next_s = ST_INIT;
            end
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_ISSUE;
                else          state_next_s = ST_IDLE;
            end
            ST_ISSUE: state_next_s = ST_RUN;
            ST_RUN: begin
                if (!run_first_r && (&rast_task_complete)) state_next_s = ST_DRAIN;
                else                                       state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if ((pending_r == '0) && !fb_valid_r) state_next_s = ST_IDLE;
                else                                  state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_INIT;
        endcase
    end

    // State register, first-RUN-cycle marker and the latched task.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_INIT;
            run_first_r <= 1'b0;
            rast_task_r <= '0;
        end else begin
            state_r     <= state_next_s;
            run_first_r <= (state_r == ST_ISSUE);
            if (accept_s) rast_task_r <= task_in;
        end
    end

    // FSM outputs are flops decoded from the next state, so they track state_r.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            task_ready_r     <= 1'b0;
            rast_next_task_r <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            task_ready_r     <= (state_next_s == ST_IDLE);
            rast_next_task_r <= (state_next_s == ST_ISSUE);
            busy_r           <= (state_next_s != ST_IDLE);
        end
    end

    // Per-requester masks: the one currently in fb_data, and its acknowledge.
    always_comb begin
        in_flight_s = '0;
        ack_next_s  = '0;
        for (int i = 0; i < N_RAST; i++) begin
            in_flight_s[i] = fb_valid_r && (fb_src_r == IDX_W'(i));
            ack_next_s[i]  = fire_s && (fb_src_r == IDX_W'(i));
        end
    end

    rr_arbiter #(.N(N_RAST)) u_rr_arbiter (
        .req       (arb_req_s),
        .pointer   (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Capture pixel pulses; a pulse on a still-pending requester is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r  <= '0;
            hold_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < N_RAST; i++) begin
                if (rast_data_write[i] && !pending_r[i]) begin
                    pending_r[i] <= 1'b1;
                    hold_r[i]    <= rast_data[i];
                end else if (ack_next_s[i]) begin
                    pending_r[i] <= 1'b0;
                end
            end
            if (|(rast_data_write & pending_r)) overflow_r <= 1'b1;
        end
    end

    // Framebuffer output register, round-robin pointer and acknowledge pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fb_data_r  <= '0;
            fb_valid_r <= 1'b0;
            fb_src_r   <= '0;
            rr_ptr_r   <= '0;
            ack_r      <= '0;
        end else begin
            ack_r <= ack_next_s;
            if (grant_valid_s) begin
                fb_data_r  <= hold_r[grant_idx_s];
                fb_src_r   <= grant_idx_s;
                fb_valid_r <= 1'b1;
                rr_ptr_r   <= (grant_idx_s == IDX_W'(N_RAST - 1)) ? '0 : grant_idx_s + IDX_W'(1);
            end else if (fire_s) begin
                fb_valid_r <= 1'b0;
            end
        end
    end

`ifdef RASTER_SCHEDULER_STATS_EN
    logic [31:0] pixel_count_r;
    logic [15:0] task_count_r;

    // Count framebuffer handshakes and accepted tasks; both wrap at max.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_count_r <= 32'd0;
            task_count_r  <= 16'd0;
        end else begin
            if (fire_s)   pixel_count_r <= pixel_count_r + 32'd1;
            if (accept_s) task_count_r  <= task_count_r + 16'd1;
        end
    end

    assign pixel_count = pixel_count_r;
    assign task_count  = task_count_r;
`endif

    assign task_ready          = task_ready_r;
    assign rast_task           = rast_task_r;
    assign rast_next_task      = rast_next_task_r;
    assign busy                = busy_r;
    assign overflow_err        = overflow_r;
    assign fb_data             = fb_data_r;
    assign fb_valid            = fb_valid_r;
    assign rast_output_written = ack_r;

endmodule

// File: tb/tb_raster_scheduler.sv
// Self-checking bench for raster_scheduler with N_RAST=4: table-driven pixel
// bursts checked by a framebuffer scoreboard, plus hand-written task sequences.
module tb_raster_scheduler;
    import raster_scheduler_pkg::*;

    localparam int N = 4;

    logic              clock = 1'b0;
    logic              reset;
    object_t           task_in;
    logic              task_valid;
    logic              task_ready;
    object_t           rast_task;
    logic              rast_next_task;
    logic [N-1:0]      rast_task_complete;
    pixel_info_t [N-1:0] rast_data;
    logic [N-1:0]      rast_data_write;
    logic [N-1:0]      rast_output_written;
    pixel_info_t       fb_data;
    logic              fb_valid;
    logic              fb_ready;
    logic              busy;
    logic              overflow_err;
`ifdef RASTER_SCHEDULER_STATS_EN
    logic [31:0]       pixel_count;
    logic [15:0]       task_count;
`endif

    raster_scheduler #(.N_RAST(N)) dut (
        .clock               (clock),
        .reset               (reset),
        .task_in             (task_in),
        .task_valid          (task_valid),
        .task_ready          (task_ready),
        .rast_task           (rast_task),
        .rast_next_task      (rast_next_task),
        .rast_task_complete  (rast_task_complete),
        .rast_data           (rast_data),
        .rast_data_write     (rast_data_write),
        .rast_output_written (rast_output_written),
        .fb_data             (fb_data),
        .fb_valid            (fb_valid),
        .fb_ready            (fb_ready),
        .busy                (busy),
        .overflow_err        (overflow_err)
`ifdef RASTER_SCHEDULER_STATS_EN
        ,
        .pixel_count         (pixel_count),
        .task_count          (task_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        pixel_info_t pix;
        int          src;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         stall;
    } vec_t;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      hs_count = 0;
    int      model_ptr = 0;
    logic    mon_en = 1'b0;
    exp_t    sb_q[$];
    vec_t    vecs[6];
    object_t objs[3];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Framebuffer monitor: checks each handshake against the scoreboard and
    // the one-cycle acknowledge that must follow it.
    initial begin
        logic [N-1:0] exp_ack;
        exp_t         e;
        exp_ack = '0;
        forever begin
            @(negedge clock);
            #2;
            if (reset || !mon_en) begin
                exp_ack = '0;
            end else begin
                chk_vec("ack", 128'(rast_output_written), 128'(exp_ack));
                exp_ack = '0;
                if (fb_valid && fb_ready) begin
                    chk_bit("sb_nonempty", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk_vec("fb_data", 128'(fb_data), 128'(e.pix));
                        exp_ack[e.src] = 1'b1;
                        hs_count++;
                    end
                end
            end
        end
    end

    function automatic pixel_info_t mk_pix(input int tag, input int src);
        pixel_info_t p;
        p.x     = 16'(tag * 16 + src + 1);
        p.y     = 16'(200 + tag);
        p.color = 24'(24'h00A000 + tag * 8 + src);
        return p;
    endfunction

    // One full task: accept, pulse, RUN with a pixel, DRAIN waiting for the fb.
    task automatic run_task(input object_t obj, input int src);
        int waited;
        chk_bit("idle_ready", task_ready, 1'b1);
        task_in    = obj;
        task_valid = 1'b1;
        @(negedge clock);
        chk_bit("issue_pulse", rast_next_task, 1'b1);
        chk_vec("rast_task", 128'(rast_task), 128'(obj));
        chk_bit("issue_not_ready", task_ready, 1'b0);
        task_valid = 1'b0;
        task_in    = ~obj;
        @(negedge clock);
        chk_bit("pulse_one_cycle", rast_next_task, 1'b0);
        rast_task_complete = '0;
        @(negedge clock);
        rast_data[src]  = mk_pix(50 + src, src);
        rast_data_write = 4'(1 << src);
        sb_q.push_back('{pix: mk_pix(50 + src, src), src: src});
        model_ptr = (src + 1) % N;
        @(negedge clock);
        rast_data_write = '0;
        chk_bit("run_first_ignored", task_ready, 1'b0);
        repeat (2) begin
            @(negedge clock);
            chk_bit("run_not_ready", task_ready, 1'b0);
            chk_vec("rast_task_stable", 128'(rast_task), 128'(obj));
        end
        rast_task_complete = '1;
        repeat (2) begin
            @(negedge clock);
            chk_bit("drain_busy", busy, 1'b1);
            chk_bit("drain_not_ready", task_ready, 1'b0);
            chk_vec("drain_task_stable", 128'(rast_task), 128'(obj));
        end
        fb_ready = 1'b1;
        waited = 0;
        while (!task_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        chk_bit("drain_exit", task_ready, 1'b1);
        chk_bit("drain_fb_empty", fb_valid, 1'b0);
        fb_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b1111, 0};
        vecs[1] = '{4'b0101, 0};
        vecs[2] = '{4'b1010, 5};
        vecs[3] = '{4'b0110, 0};
        vecs[4] = '{4'b1000, 2};
        vecs[5] = '{4'b1101, 0};
        objs[0] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 24'hFF0000};
        objs[1] = '{16'd1,  16'd2,  16'd3,  16'd4,  16'd5,  16'd6,  24'h00FF00};
        objs[2] = '{16'hAAAA, 16'h5555, 16'h1234, 16'h4321, 16'h0F0F, 16'hF0F0, 24'h0000FF};

        reset              = 1'b1;
        task_in            = '0;
        task_valid         = 1'b0;
        rast_task_complete = '0;
        rast_data          = '0;
        rast_data_write    = '0;
        fb_ready           = 1'b0;
        repeat (3) @(negedge clock);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_ready", task_ready, 1'b0);
        chk_bit("rst_next_task", rast_next_task, 1'b0);
        chk_bit("rst_fb_valid", fb_valid, 1'b0);
        chk_bit("rst_overflow", overflow_err, 1'b0);
        chk_vec("rst_rast_task", 128'(rast_task), 128'(0));
        chk_vec("rst_ack", 128'(rast_output_written), 128'(0));

        // Rasterizers free-run after reset: INIT until all flags rise.
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk_bit("init_busy", busy, 1'b1);
            chk_bit("init_not_ready", task_ready, 1'b0);
        end
        rast_task_complete = '1;
        chk_bit("init_ready_same_cycle", task_ready, 1'b0);
        @(negedge clock);
        chk_bit("idle_after_flags", task_ready, 1'b1);
        chk_bit("idle_not_busy", busy, 1'b0);
        mon_en = 1'b1;

        for (int t = 0; t < 3; t++) run_task(objs[t], t + 1);

        // Table-driven pixel bursts: simultaneous pulses, optional fb stall.
        for (int v = 0; v < 6; v++) begin
            int last;
            int cnt;
            last = -1;
            cnt  = $countones(vecs[v].mask);
            for (int k = 0; k < N; k++) begin
                int i;
                i = (model_ptr + k) % N;
                if (vecs[v].mask[i]) begin
                    sb_q.push_back('{pix: mk_pix(v, i), src: i});
                    last = i;
                end
            end
            if (last >= 0) model_ptr = (last + 1) % N;
            for (int i = 0; i < N; i++) rast_data[i] = mk_pix(v, i);
            rast_data_write = vecs[v].mask;
            fb_ready        = (vecs[v].stall == 0);
            @(negedge clock);
            rast_data_write = '0;
            chk_bit("lat_not_1", fb_valid, 1'b0);
            @(negedge clock);
            chk_bit("lat_2", fb_valid, 1'b1);
            if (vecs[v].stall > 0) begin
                for (int s = 1; s < vecs[v].stall; s++) begin
                    @(negedge clock);
                    chk_bit("stall_valid", fb_valid, 1'b1);
                    chk_vec("stall_data", 128'(fb_data), 128'(sb_q[0].pix));
                end
                fb_ready = 1'b1;
            end
            for (int j = 1; j < cnt; j++) begin
                @(negedge clock);
                chk_bit("back_to_back", fb_valid, 1'b1);
            end
            @(negedge clock);
            chk_bit("idle_after_burst", fb_valid, 1'b0);
            @(negedge clock);
            chk_bit("sb_drained", sb_q.size() == 0, 1'b1);
            fb_ready = 1'b0;
        end
        chk_bit("no_overflow_yet", overflow_err, 1'b0);

        // Second pulse on requester 2 before its acknowledge is dropped.
        rast_data[2]    = mk_pix(90, 2);
        rast_data_write = 4'b0100;
        sb_q.push_back('{pix: mk_pix(90, 2), src: 2});
        model_ptr = 3;
        @(negedge clock);
        rast_data_write = '0;
        chk_bit("ovf_clear_before", overflow_err, 1'b0);
        @(negedge clock);
        rast_data[2]    = mk_pix(91, 2);
        rast_data_write = 4'b0100;
        @(negedge clock);
        rast_data_write = '0;
        chk_bit("ovf_set", overflow_err, 1'b1);
        chk_vec("ovf_first_kept", 128'(fb_data), 128'(mk_pix(90, 2)));
        fb_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk_bit("ovf_only_one", fb_valid, 1'b0);
        chk_bit("ovf_sticky", overflow_err, 1'b1);
        chk_bit("ovf_sb_drained", sb_q.size() == 0, 1'b1);
        fb_ready = 1'b0;

`ifdef RASTER_SCHEDULER_STATS_EN
        chk_vec("task_count", 128'(task_count), 128'(3));
        chk_vec("pixel_count", 128'(pixel_count), 128'(hs_count));
`endif

        // Reset with a pixel held in fb_data: it is discarded, never acknowledged.
        rast_data[1]    = mk_pix(95, 1);
        rast_data_write = 4'b0010;
        @(negedge clock);
        rast_data_write = '0;
        @(negedge clock);
        chk_bit("held_before_reset", fb_valid, 1'b1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk_bit("mid_rst_fb_valid", fb_valid, 1'b0);
        chk_bit("mid_rst_overflow", overflow_err, 1'b0);
        chk_bit("mid_rst_busy", busy, 1'b0);
        @(negedge clock);
        reset    = 1'b0;
        fb_ready = 1'b1;
        mon_en   = 1'b1;
        repeat (4) @(negedge clock);
        chk_bit("post_rst_no_pixel", fb_valid, 1'b0);
        chk_vec("post_rst_no_ack", 128'(rast_output_written), 128'(0));
        chk_bit("post_rst_idle", task_ready, 1'b1);
`ifdef RASTER_SCHEDULER_STATS_EN
        chk_vec("post_rst_pixel_count", 128'(pixel_count), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raster_scheduler.md
RASTER_SCHEDULER -- requirements
Module: raster_scheduler

Interface
REQ-001 SHALL have parameter N_RAST, default 16, meaning the number of attached rasterizer instances (2..32).
REQ-002 SHALL have port: clock  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: task_in  input  object_t  next triangle to draw.
REQ-005 SHALL have port: task_valid  input  1  task_in valid.
REQ-006 SHALL have port: task_ready  output  1  scheduler accepts task_in this cycle.
REQ-007 SHALL have port: rast_task  output  object_t  task broadcast to all rasterizers.
REQ-008 SHALL have port: rast_next_task  output  1  one-cycle start pulse broadcast to all rasterizers.
REQ-009 SHALL have port: rast_task_complete  input  N_RAST  per-rasterizer completion flags.
REQ-010 SHALL have port: rast_data  input  N_RAST x pixel_info_t  per-rasterizer pixel outputs.
REQ-011 SHALL have port: rast_data_write  input  N_RAST  per-rasterizer one-cycle pixel-write pulses.
REQ-012 SHALL have port: rast_output_written  output  N_RAST  per-rasterizer one-cycle write acknowledges.
REQ-013 SHALL have port: fb_data  output  pixel_info_t  pixel to the framebuffer.
REQ-014 SHALL have port: fb_valid  output  1  fb_data valid.
REQ-015 SHALL have port: fb_ready  input  1  framebuffer accepts fb_data this cycle.
REQ-016 SHALL have port: busy  output  1  scheduler is not in IDLE.
REQ-017 SHALL have port: overflow_err  output  1  sticky error, set when a pixel pulse is dropped.

Function
REQ-018 SHALL implement task FSM states INIT, IDLE, ISSUE, RUN, DRAIN.
REQ-019 SHALL transition INIT->IDLE once rast_task_complete is all ones, because rasterizers free-run one pass after reset.
REQ-020 SHALL assert task_ready only in IDLE; on task_valid&task_ready it SHALL register task_in into rast_task and go to ISSUE.
REQ-021 SHALL assert rast_next_task for exactly the one ISSUE cycle, then go to RUN.
REQ-022 SHALL ignore rast_task_complete during the first RUN cycle (flags clear one cycle after the pulse); from the second RUN cycle, all ones SHALL move the FSM to DRAIN.
REQ-023 SHALL leave DRAIN for IDLE when no pixel is pending and fb_valid is low.
REQ-024 SHALL hold rast_task stable from ISSUE through DRAIN.
REQ-025 SHALL keep one pending flag plus a pixel_info_t holding register per rasterizer; a rast_data_write[i] pulse SHALL latch rast_data[i] and set pending[i] at the next edge.
REQ-026 SHALL drop a pulse on requester i while pending[i] is set or awaiting acknowledge, keep the held pixel, and set overflow_err.
REQ-027 SHALL grant among pending requesters round-robin whenever fb_valid is low or fb_valid&fb_ready; after granting i, priority starts at i+1 mod N_RAST.
REQ-028 SHALL register the granted pixel into fb_data and raise fb_valid at the edge after grant, and hold fb_data and fb_valid stable until fb_ready.
REQ-029 SHALL, on fb_valid&fb_ready for requester i, clear pending[i] and pulse rast_output_written[i] for one cycle in the following cycle.
REQ-030 SHALL sustain one pixel per cycle when fb_ready is held high and at least one requester is pending.
REQ-031 SHALL give the minimum latency rast_data_write pulse -> fb_valid of 2 cycles.
REQ-032 SHALL keep the arbiter running in every FSM state, including INIT.

Reset
REQ-033 SHALL, during reset, put the FSM in INIT; set rast_task to all zeros, pending to zero, the round-robin pointer to 0, and overflow_err to 0; and drive all outputs low.
REQ-034 SHALL, on reset mid-operation, discard held pixels without acknowledging them.

Configuration
REQ-035 SHALL, with RASTER_SCHEDULER_STATS_EN defined, add outputs pixel_count (32 bits, incremented per fb handshake) and task_count (16 bits, incremented per accepted task); both wrap at max and reset to 0.
REQ-036 SHALL, with RASTER_SCHEDULER_STATS_EN undefined, omit those ports and counters entirely.

Structure
REQ-037 SHALL use object_t and pixel_info_t from the common package, and SHALL add the scheduler_state_t enum there.
REQ-038 SHALL place the round-robin arbiter in sub-module rr_arbiter (parameter N; inputs req and pointer; outputs one-hot grant and grant index).

Verification
REQ-039 SHALL verify reset release with rast_task_complete=0 for 10 cycles then all ones -> busy high; task_ready=0 until the cycle after the all-ones flags; then IDLE.
REQ-040 SHALL verify one task accepted in IDLE -> rast_next_task high exactly 1 cycle; rast_task equals task_in; task_ready low until DRAIN exits.
REQ-041 SHALL verify, with N_RAST=4, simultaneous pulses on requesters 0..3 and fb_ready=1 -> fb_valid for 4 consecutive cycles in order 0,1,2,3 and rast_output_written 0..3 each pulsed once.
REQ-042 SHALL verify fb_ready=0 for 5 cycles while fb_valid is high -> fb_data unchanged, no acknowledge; fb_ready=1 -> acknowledge one cycle later.
REQ-043 SHALL verify a second pulse on requester 2 before its acknowledge -> overflow_err=1 sticky and only the first pixel delivered.
REQ-044 SHALL verify, with STATS_EN, 3 tasks and 7 pixels handshaken -> task_count=3 and pixel_count=7.
